// File: rtl/timer_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_reg_pkg
// Description : Register map, bit positions and prescaler select encoding
//               shared by the 8-bit APB timer and its prescaler.
// Revision    : 1.0
// ============================================================================
package timer_reg_pkg;

    localparam logic [7:0] c_addr_tdr  = 8'h00;
    localparam logic [7:0] c_addr_tcr  = 8'h01;
    localparam logic [7:0] c_addr_tsr  = 8'h02;
    localparam logic [7:0] c_addr_tie  = 8'h03;
    localparam logic [7:0] c_addr_tcnt = 8'h04;

    localparam int c_tcr_load = 7;
    localparam int c_tcr_down = 5;
    localparam int c_tcr_en   = 4;

    localparam int c_tsr_ovf  = 0;
    localparam int c_tsr_udf  = 1;

    localparam int c_tie_ovf  = 0;
    localparam int c_tie_udf  = 1;

    typedef enum logic [1:0] {
        DIV1 = 2'b00,
        DIV2 = 2'b01,
        DIV4 = 2'b10,
        DIV8 = 2'b11
    } cks_e;

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : timer_prescaler
// Description : Free-running 3-bit divider producing a one-cycle count tick
//               at /1, /2, /4 or /8 while enabled.
// Revision    : 1.0
// ============================================================================
module timer_prescaler
    import timer_reg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  cks_e cks_i,
    output logic tick_o
);

    logic [2:0] div_q;
    logic [2:0] div_d;

    // Divider is not cleared on a cks change, only while disabled.
    always_comb begin
        div_d = en_i ? div_q + 3'd1 : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= 3'd0;
        end else begin
            div_q <= div_d;
        end
    end

    always_comb begin
        tick_o = 1'b0;
        case (cks_i)
            DIV1:    tick_o = en_i;
            DIV2:    tick_o = en_i & div_q[0];
            DIV4:    tick_o = en_i & (&div_q[1:0]);
            DIV8:    tick_o = en_i & (&div_q);
            default: tick_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/timer_8bit_apb.sv
`default_nettype none
// ============================================================================
// Module      : timer_8bit_apb
// Description : APB slave 8-bit up/down timer with load register, prescaler,
//               sticky overflow/underflow flags and maskable level interrupt.
// Revision    : 1.0
// ============================================================================
module timer_8bit_apb
    import timer_reg_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              irq
);

    logic [7:0] tdr_q,    tdr_d;
    logic       load_q,   load_d;
    logic       down_q,   down_d;
    logic       en_q,     en_d;
    cks_e       cks_q,    cks_d;
    logic       ovf_ie_q, ovf_ie_d;
    logic       udf_ie_q, udf_ie_d;
    logic       ovf_q,    ovf_d;
    logic       udf_q,    udf_d;
    logic [7:0] cnt_q,    cnt_d;

    logic [7:0] w_addr;
    logic       w_wr;
    logic       w_wr_tsr;
    logic       w_tick;
    logic       w_ovf_set;
    logic       w_udf_set;

    assign w_addr   = paddr[7:0];
    assign w_wr     = psel & penable & pwrite;
    assign w_wr_tsr = w_wr && (w_addr == c_addr_tsr);

    assign pready   = 1'b1;
    assign pslverr  = 1'b0;

    timer_prescaler u_prescaler (
        .clk    (pclk),
        .rst    (preset),
        .en_i   (en_q),
        .cks_i  (cks_q),
        .tick_o (w_tick)
    );

    assign w_ovf_set = ~load_q & w_tick & ~down_q & (cnt_q == 8'hFF);
    assign w_udf_set = ~load_q & w_tick &  down_q & (cnt_q == 8'h00);

    always_comb begin
        tdr_d    = tdr_q;
        load_d   = load_q;
        down_d   = down_q;
        en_d     = en_q;
        cks_d    = cks_q;
        ovf_ie_d = ovf_ie_q;
        udf_ie_d = udf_ie_q;

        if (w_wr) begin
            case (w_addr)
                c_addr_tdr: tdr_d = pwdata;
                c_addr_tcr: begin
                    load_d = pwdata[c_tcr_load];
                    down_d = pwdata[c_tcr_down];
                    en_d   = pwdata[c_tcr_en];
                    cks_d  = cks_e'(pwdata[1:0]);
                end
                c_addr_tie: begin
                    ovf_ie_d = pwdata[c_tie_ovf];
                    udf_ie_d = pwdata[c_tie_udf];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_q) begin
            cnt_d = tdr_q;
        end else if (w_tick) begin
            cnt_d = down_q ? cnt_q - 8'd1 : cnt_q + 8'd1;
        end
    end

    // A hardware set in the same cycle as a software clear wins.
    assign ovf_d = w_ovf_set | (ovf_q & ~(w_wr_tsr & pwdata[c_tsr_ovf]));
    assign udf_d = w_udf_set | (udf_q & ~(w_wr_tsr & pwdata[c_tsr_udf]));

    always_ff @(posedge pclk) begin
        if (preset) begin
            tdr_q    <= 8'h00;
            load_q   <= 1'b0;
            down_q   <= 1'b0;
            en_q     <= 1'b0;
            cks_q    <= DIV1;
            ovf_ie_q <= 1'b0;
            udf_ie_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            cnt_q    <= 8'h00;
        end else begin
            tdr_q    <= tdr_d;
            load_q   <= load_d;
            down_q   <= down_d;
            en_q     <= en_d;
            cks_q    <= cks_d;
            ovf_ie_q <= ovf_ie_d;
            udf_ie_q <= udf_ie_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign irq = (ovf_q & ovf_ie_q) | (udf_q & udf_ie_q);

    always_comb begin
        prdata = 8'h00;
        if (psel && !pwrite && !preset) begin
            case (w_addr)
                c_addr_tdr:  prdata = tdr_q;
                c_addr_tcr: begin
                    prdata[c_tcr_load] = load_q;
                    prdata[c_tcr_down] = down_q;
                    prdata[c_tcr_en]   = en_q;
                    prdata[1:0]        = cks_q;
                end
                c_addr_tsr: begin
                    prdata[c_tsr_ovf] = ovf_q;
                    prdata[c_tsr_udf] = udf_q;
                end
                c_addr_tie: begin
                    prdata[c_tie_ovf] = ovf_ie_q;
                    prdata[c_tie_udf] = udf_ie_q;
                end
                c_addr_tcnt: prdata = cnt_q;
                default:     prdata = 8'h00;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_8bit_apb.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_8bit_apb
// Description : Directed plus randomized APB bench for timer_8bit_apb with an
//               arithmetic reference model of the timer behaviour.
// Revision    : 1.0
// ============================================================================
module tb_timer_8bit_apb;

    logic       pclk = 1'b0;
    logic       preset;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       irq;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0] m_tdr  = 8'h00;
    logic [7:0] m_cnt  = 8'h00;
    logic [1:0] m_cks  = 2'b00;
    logic [1:0] m_tie  = 2'b00;
    bit         m_load = 1'b0;
    bit         m_down = 1'b0;
    bit         m_en   = 1'b0;
    bit         m_ovf  = 1'b0;
    bit         m_udf  = 1'b0;
    int         m_ps   = 0;

    timer_8bit_apb #(.ADDR_W(8)) dut (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .irq     (irq)
    );

    always #5 pclk = ~pclk;

    function automatic logic [7:0] exp_rd(logic [7:0] a);
        case (a)
            8'h00:   return m_tdr;
            8'h01:   return {m_load, 1'b0, m_down, m_en, 2'b00, m_cks};
            8'h02:   return {6'b0, m_udf, m_ovf};
            8'h03:   return {6'b0, m_tie};
            8'h04:   return m_cnt;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic exp_irq();
        return (m_ovf & m_tie[0]) | (m_udf & m_tie[1]);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the bus values present at it.
    task automatic model_step();
        bit         wr;
        bit         tick;
        bit         set_o;
        bit         set_u;
        int         div;
        logic [7:0] n_cnt;
        if (preset) begin
            m_tdr = 0; m_cnt = 0; m_cks = 0; m_tie = 0;
            m_load = 0; m_down = 0; m_en = 0; m_ovf = 0; m_udf = 0; m_ps = 0;
            return;
        end
        wr    = psel & penable & pwrite;
        div   = 1 << m_cks;
        tick  = m_en && ((m_ps % div) == div - 1);
        n_cnt = m_cnt;
        set_o = 0;
        set_u = 0;
        if (m_load) begin
            n_cnt = m_tdr;
        end else if (tick && !m_down) begin
            n_cnt = 8'((int'(m_cnt) + 1) % 256);
            set_o = (m_cnt == 8'd255);
        end else if (tick && m_down) begin
            n_cnt = 8'((int'(m_cnt) + 255) % 256);
            set_u = (m_cnt == 8'd0);
        end
        m_ovf = set_o | (m_ovf & !(wr && paddr == 8'h02 && pwdata[0]));
        m_udf = set_u | (m_udf & !(wr && paddr == 8'h02 && pwdata[1]));
        m_ps  = m_en ? (m_ps + 1) % 8 : 0;
        m_cnt = n_cnt;
        if (wr) begin
            case (paddr)
                8'h00: m_tdr = pwdata;
                8'h01: begin
                    m_load = pwdata[7];
                    m_down = pwdata[5];
                    m_en   = pwdata[4];
                    m_cks  = pwdata[1:0];
                end
                8'h03: m_tie = pwdata[1:0];
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge pclk);
        model_step();
        @(negedge pclk);
        #1;
        chk("irq", {7'b0, irq}, {7'b0, exp_irq()});
    endtask

    task automatic bus_idle();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        cycle();
        penable = 1'b1;
        cycle();
        bus_idle();
    endtask

    task automatic apb_read(input logic [7:0] a, input string tag, output logic [7:0] obs);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        cycle();
        penable = 1'b1;
        #1;
        obs = prdata;
        chk(tag, prdata, exp_rd(a));
        cycle();
        bus_idle();
    endtask

    // Hold a read setup phase on TCNT so the count is visible every cycle.
    task automatic peek(input int n);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 8'h04;
        for (int i = 0; i < n; i++) begin
            cycle();
            chk("tcnt_peek", prdata, m_cnt);
        end
    endtask

    logic [7:0] rd;
    int         r;

    initial begin
        preset = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        cycle();
        cycle();
        preset = 1'b0;
        chk("reset_irq", {7'b0, irq}, 8'h00);

        foreach (rd[i]) begin end
        for (int a = 0; a <= 4; a++) begin
            apb_read(8'(a), "reset_reg", rd);
            chk("reset_reg_const", rd, 8'h00);
        end
        apb_read(8'h10, "reserved", rd);
        chk("reserved_const", rd, 8'h00);

        apb_write(8'h01, 8'hFF);
        apb_read(8'h01, "tcr_mask", rd);
        chk("tcr_mask_const", rd, 8'hB3);
        apb_write(8'h03, 8'hFF);
        apb_read(8'h03, "tie_mask", rd);
        chk("tie_mask_const", rd, 8'h03);
        apb_write(8'h01, 8'h00);
        apb_write(8'h03, 8'h00);
        apb_write(8'h02, 8'h03);

        // Up count through the 0xFF -> 0x00 wrap
        apb_write(8'h00, 8'hFA);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h10);
        peek(8);
        bus_idle();
        apb_read(8'h02, "tsr_ovf", rd);
        chk("tsr_ovf_const", rd, 8'h01);
        chk("irq_masked", {7'b0, irq}, 8'h00);
        apb_write(8'h03, 8'h01);
        chk("irq_ovf_ie", {7'b0, irq}, 8'h01);
        apb_write(8'h02, 8'h01);
        chk("irq_cleared", {7'b0, irq}, 8'h00);

        // Down count /8 through the 0x00 -> 0xFF wrap
        apb_write(8'h01, 8'h80);
        apb_write(8'h00, 8'h03);
        apb_write(8'h03, 8'h02);
        apb_write(8'h01, 8'h33);
        peek(40);
        bus_idle();
        apb_read(8'h02, "tsr_udf", rd);
        chk("tsr_udf_const", rd, 8'h02);
        chk("irq_udf", {7'b0, irq}, 8'h01);

        // Prescaler /2 and /4 from zero
        apb_write(8'h02, 8'h03);
        apb_write(8'h00, 8'h00);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h11);
        peek(20);
        chk("div2_count", prdata, 8'h0A);
        bus_idle();
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h12);
        peek(20);
        chk("div4_count", prdata, 8'h05);
        bus_idle();

        // Hardware set collides with software clear
        apb_write(8'h03, 8'h00);
        apb_write(8'h00, 8'hFE);
        apb_write(8'h01, 8'h80);
        apb_write(8'h02, 8'h03);
        apb_write(8'h01, 8'h10);
        apb_write(8'h02, 8'h01);
        apb_read(8'h02, "set_wins", rd);
        chk("set_wins_const", rd, 8'h01);
        apb_write(8'h02, 8'h00);
        apb_read(8'h02, "w0_noeffect", rd);
        chk("w0_noeffect_const", rd, 8'h01);
        apb_write(8'h03, 8'h01);
        chk("irq_before_reset", {7'b0, irq}, 8'h01);

        // Reset pulse while counting
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 8'h04;
        preset = 1'b1;
        cycle();
        chk("prdata_in_reset", prdata, 8'h00);
        chk("irq_after_reset", {7'b0, irq}, 8'h00);
        preset = 1'b0;
        bus_idle();
        apb_read(8'h01, "tcr_after_reset", rd);
        chk("tcr_after_reset_const", rd, 8'h00);
        apb_read(8'h02, "tsr_after_reset", rd);
        chk("tsr_after_reset_const", rd, 8'h00);
        peek(5);
        chk("count_stopped", prdata, 8'h00);
        bus_idle();

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 59) == 0) begin
                preset = 1'b1;
                cycle();
                preset = 1'b0;
            end else if (r < 4) begin
                if ($urandom_range(0, 7) == 0)
                    apb_write(8'($urandom), 8'($urandom));
                else
                    apb_write(8'($urandom_range(0, 5)), 8'($urandom));
            end else if (r < 7) begin
                if ($urandom_range(0, 7) == 0)
                    apb_read(8'($urandom), "rand_read", rd);
                else
                    apb_read(8'($urandom_range(0, 5)), "rand_read", rd);
            end else begin
                peek(int'($urandom_range(1, 12)));
                bus_idle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
